// File: rtl/add4_tester_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : add4_tester_if
// Description : Bundle of the signals between the 4-bit adder board tester
//               and its environment (operand pins, returned sum, run control
//               and sweep results).
// Revision    : 1.0 - initial release
// ============================================================================
interface add4_tester_if;
  logic       start;
  logic [3:0] a_out;
  logic [3:0] b_out;
  logic [4:0] sum_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [8:0] err_count;
  logic [7:0] first_fail;

  // Tester side: drives the operands and reports results.
  modport master (
    input  start, sum_in,
    output a_out, b_out, busy, done, pass, err_count, first_fail
  );

  // Environment side: adder board plus whoever issues start.
  modport slave (
    output start, sum_in,
    input  a_out, b_out, busy, done, pass, err_count, first_fail
  );
endinterface
`default_nettype wire

// File: rtl/add4_tester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : add4_tester
// Description : Exhaustive sweep tester for an external 4-bit adder board.
//               Drives all 256 {b,a} operand pairs, waits SETTLE_CYCLES for
//               the board, compares the synchronized sum and records the
//               mismatch count and the first failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module add4_tester #(
  parameter int SETTLE_CYCLES = 4
) (
  input  wire logic      clk,
  input  wire logic      resetn,
  add4_tester_if.master  bus
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [8:0] err_q, err_d;
  logic [7:0] ff_q, ff_d;
  logic [4:0] sync1_q, sync2_q;
  logic [4:0] w_expected;

  // Two-flop synchronizer for the sum coming back from the board.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 5'd0;
      sync2_q <= 5'd0;
    end else begin
      sync1_q <= bus.sum_in;
      sync2_q <= sync1_q;
    end
  end

  // Sweep state registers; reset abandons any sweep in progress.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      idx_q   <= 8'd0;
      cnt_q   <= 8'd0;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      err_q   <= 9'd0;
      ff_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // Zero-extended reference sum, so a carry out of bit 3 is kept.
  assign w_expected = {1'b0, a_q} + {1'b0, b_q};

  // Next-state and datapath updates of the sweep FSM.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    err_d   = err_q;
    ff_d    = ff_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          idx_d   = 8'd0;
          err_d   = 9'd0;
          ff_d    = 8'd0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        a_d     = idx_q[3:0];
        b_d     = idx_q[7:4];
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (sync2_q != w_expected) begin
          // At most 256 vectors, so 9 bits saturate naturally; guard anyway.
          if (err_q != 9'd256) begin
            err_d = err_q + 9'd1;
          end
          if (err_q == 9'd0) begin
            ff_d = idx_q;
          end
        end
        if (idx_q == 8'd255) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = ST_DRIVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status flags decode straight from the state, so reset clears them at once.
  assign bus.busy       = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) ||
                          (state_q == ST_CHECK);
  assign bus.done       = (state_q == ST_DONE);
  assign bus.pass       = (state_q == ST_DONE) && (err_q == 9'd0);
  assign bus.a_out      = a_q;
  assign bus.b_out      = b_q;
  assign bus.err_count  = err_q;
  assign bus.first_fail = ff_q;

endmodule
`default_nettype wire

// File: tb/tb_add4_tester.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_add4_tester
// Description : Directed bench for add4_tester. Two testers (settle 4 and 3)
//               each talk to a behavioural adder board whose fault mode and
//               pipeline depth can be changed between sweeps. Board depth d
//               gives a round trip of d+2 cycles through the synchronizer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add4_tester;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn4, rstn3;
  add4_tester_if if4();
  add4_tester_if if3();

  add4_tester #(.SETTLE_CYCLES(4)) u_dut4 (.clk(clk), .resetn(rstn4), .bus(if4.master));
  add4_tester #(.SETTLE_CYCLES(3)) u_dut3 (.clk(clk), .resetn(rstn3), .bus(if3.master));

  // Board modes: 0 correct, 1 sum bit 4 stuck at 0, 2 a+b+1 only for a=3,b=5
  int mode4, depth4, mode3, depth3;
  logic [4:0] pipe4 [0:3];
  logic [4:0] pipe3 [0:3];

  function automatic logic [4:0] board_sum(input int mode, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (mode == 1) s[4] = 1'b0;
    if (mode == 2 && a == 4'd3 && b == 4'd5) s = s + 5'd1;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    pipe4[0] <= board_sum(mode4, if4.a_out, if4.b_out);
    pipe3[0] <= board_sum(mode3, if3.a_out, if3.b_out);
    for (int i = 1; i < 4; i++) begin
      pipe4[i] <= pipe4[i-1];
      pipe3[i] <= pipe3[i-1];
    end
  end
  assign if4.sum_in = pipe4[depth4-1];
  assign if3.sum_in = pipe3[depth3-1];

  int nvec = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int sel);
    return (sel == 4) ? if4.busy : if3.busy;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 4) if4.start = v;
    else          if3.start = v;
  endtask

  // Pulse start, then count negedges with busy high; optional start pokes
  // while busy must not disturb the sweep.
  task automatic sweep(input int sel, input bit poke, output int cycles);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    cycles = 0;
    while (busy_of(sel) && cycles < 4000) begin
      cycles++;
      set_start(sel, (poke && (cycles % 97 == 5) && cycles < 1400));
      @(negedge clk);
    end
    set_start(sel, 1'b0);
  endtask

  int cyc;
  int w;

  initial begin
    if4.start = 1'b0;
    if3.start = 1'b0;
    mode4 = 0; depth4 = 1;
    mode3 = 0; depth3 = 1;
    rstn4 = 1'b0;
    rstn3 = 1'b0;
    #23;
    check("rst_busy",   {31'd0, if4.busy},  0);
    check("rst_done",   {31'd0, if4.done},  0);
    check("rst_pass",   {31'd0, if4.pass},  0);
    check("rst_err",    {23'd0, if4.err_count},  0);
    check("rst_ff",     {24'd0, if4.first_fail}, 0);
    check("rst_a",      {28'd0, if4.a_out}, 0);
    check("rst_b",      {28'd0, if4.b_out}, 0);
    @(negedge clk);
    rstn4 = 1'b1;
    rstn3 = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_no_start_busy", {31'd0, if4.busy}, 0);
    check("idle_no_start_done", {31'd0, if4.done}, 0);

    // Correct board, settle 4: 256*6 busy cycles, clean pass
    sweep(4, 1'b0, cyc);
    check("good_cycles", cyc, 1536);
    check("good_done",   {31'd0, if4.done}, 1);
    check("good_pass",   {31'd0, if4.pass}, 1);
    check("good_err",    {23'd0, if4.err_count}, 0);
    check("good_busy_off", {31'd0, if4.busy}, 0);

    // Sum bit 4 stuck low: every a+b>=16 fails, first at {b=1,a=15}
    mode4 = 1;
    sweep(4, 1'b0, cyc);
    check("stuck_cycles", cyc, 1536);
    check("stuck_done",   {31'd0, if4.done}, 1);
    check("stuck_pass",   {31'd0, if4.pass}, 0);
    check("stuck_err",    {23'd0, if4.err_count}, 120);
    check("stuck_ff",     {24'd0, if4.first_fail}, 32'h1F);
    repeat (10) @(negedge clk);
    check("stuck_hold_done", {31'd0, if4.done}, 1);
    check("stuck_hold_err",  {23'd0, if4.err_count}, 120);

    // Restart from DONE with correct board, poking start while busy
    mode4 = 0;
    sweep(4, 1'b1, cyc);
    check("rerun_cycles", cyc, 1536);
    check("rerun_err",    {23'd0, if4.err_count}, 0);
    check("rerun_pass",   {31'd0, if4.pass}, 1);

    // Single bad vector a=3,b=5
    mode4 = 2;
    sweep(4, 1'b0, cyc);
    check("single_err",  {23'd0, if4.err_count}, 1);
    check("single_ff",   {24'd0, if4.first_fail}, 32'h53);
    check("single_pass", {31'd0, if4.pass}, 0);
    check("single_done", {31'd0, if4.done}, 1);

    // Reset mid-sweep at idx 100 ({b=6,a=4}) with a stuck board so err is nonzero
    mode4 = 1;
    @(negedge clk);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    w = 0;
    while (!(if4.a_out == 4'd4 && if4.b_out == 4'd6) && w < 2000) begin
      @(negedge clk);
      w++;
    end
    check("reach_idx100", {31'd0, (w < 2000)}, 1);
    check("mid_err_nonzero", {31'd0, (if4.err_count != 9'd0)}, 1);
    #2;
    rstn4 = 1'b0;
    #1;
    check("arst_busy", {31'd0, if4.busy}, 0);
    check("arst_done", {31'd0, if4.done}, 0);
    check("arst_pass", {31'd0, if4.pass}, 0);
    check("arst_err",  {23'd0, if4.err_count},  0);
    check("arst_ff",   {24'd0, if4.first_fail}, 0);
    check("arst_a",    {28'd0, if4.a_out}, 0);
    check("arst_b",    {28'd0, if4.b_out}, 0);
    @(negedge clk);
    rstn4 = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {31'd0, if4.busy}, 0);
    mode4 = 0;
    sweep(4, 1'b0, cyc);
    check("post_rst_cycles", cyc, 1536);
    check("post_rst_err",  {23'd0, if4.err_count}, 0);
    check("post_rst_pass", {31'd0, if4.pass}, 1);

    // Settle 3: round trip of 3 cycles fits, 6 does not
    depth3 = 1;
    sweep(3, 1'b0, cyc);
    check("s3_lat3_cycles", cyc, 1280);
    check("s3_lat3_pass", {31'd0, if3.pass}, 1);
    check("s3_lat3_err",  {23'd0, if3.err_count}, 0);
    depth3 = 4;
    sweep(3, 1'b0, cyc);
    check("s3_lat6_done", {31'd0, if3.done}, 1);
    check("s3_lat6_pass", {31'd0, if3.pass}, 0);
    check("s3_lat6_err_nonzero", {31'd0, (if3.err_count != 9'd0)}, 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
